// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 one-bit mux.
// Optional hold limit compiled in with `define MUX_ARB_HOLD_LIMIT_EN.
module mux_4to1_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] In,
    output logic [1:0] Sel,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       out
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic [3:0] others;
    logic [1:0] k_idle;
    logic [1:0] k_hand;
    logic       rotate;

`ifdef MUX_ARB_HOLD_LIMIT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
`else
    logic       unused_hold_last;
    assign unused_hold_last = ^HOLD_LAST;
`endif

    // First set bit of m, searching upward from p and wrapping.
    function automatic logic [1:0] pick(
        input logic [1:0] p,
        input logic [3:0] m
    );
        logic [1:0] k;
        logic [1:0] idx;
        logic       hit;
        k   = p;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!hit && m[idx]) begin
                k   = idx;
                hit = 1'b1;
            end
        end
        return k;
    endfunction

    assign others = req & ~(4'b0001 << sel_q);
    assign k_idle = pick(ptr_q, req);
    assign k_hand = pick(ptr_q, others);

`ifdef MUX_ARB_HOLD_LIMIT_EN
    assign rotate = (hold_cnt_q == HOLD_LAST) && (|others);
`else
    assign rotate = 1'b0;
`endif

    // Next-state: grant load, hold, zero-bubble handoff and release.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
`ifdef MUX_ARB_HOLD_LIMIT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    sel_d   = k_idle;
                    gnt_d   = 4'b0001 << k_idle;
                    busy_d  = 1'b1;
                    ptr_d   = k_idle + 2'd1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
                    hold_cnt_d = 8'd0;
`endif
                end else begin
                    gnt_d  = 4'b0000;
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                if (req[sel_q] && !rotate) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = 8'd0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
`endif
                end else if (|others) begin
                    sel_d = k_hand;
                    gnt_d = 4'b0001 << k_hand;
                    ptr_d = k_hand + 2'd1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
                    hold_cnt_d = 8'd0;
`endif
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_cnt_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign Sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign out  = In[sel_q] & busy_q;

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Scoreboard bench for mux_4to1_rr_arbiter: directed vectors push expected
// outputs per cycle; a negedge monitor pops and compares.
module tb_mux_4to1_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] In;
    logic [1:0] Sel;
    logic [3:0] gnt;
    logic       busy;
    logic       out;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       o;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passed = 0;

    mux_4to1_rr_arbiter #(
        .HOLD_MAX(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .In  (In),
        .Sel (Sel),
        .gnt (gnt),
        .busy(busy),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: compare the DUT against the entry scheduled for this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            $display("FAIL %s: entry for cycle %0d never checked (now %0d)",
                     e.tag, e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            checks++;
            if (gnt === e.g) passed++;
            else $display("FAIL %s gnt @%0d: got %b want %b", e.tag, cyc, gnt, e.g);
            checks++;
            if (Sel === e.s) passed++;
            else $display("FAIL %s Sel @%0d: got %0d want %0d", e.tag, cyc, Sel, e.s);
            checks++;
            if (busy === e.b) passed++;
            else $display("FAIL %s busy @%0d: got %b want %b", e.tag, cyc, busy, e.b);
            checks++;
            if (out === e.o) passed++;
            else $display("FAIL %s out @%0d: got %b want %b", e.tag, cyc, out, e.o);
        end
    end

    // One cycle: expectations describe outputs visible now; the inputs
    // driven here are sampled at the next rising edge.
    task automatic step(
        input logic       r,
        input logic [3:0] rq,
        input logic [3:0] din,
        input logic [3:0] eg,
        input logic [1:0] es,
        input logic       eo,
        input string      tag
    );
        exp_t e;
        @(posedge clk);
        #2;
        rst = r;
        req = rq;
        In  = din;
        e.cyc = cyc;
        e.g   = eg;
        e.s   = es;
        e.b   = |eg;
        e.o   = eo;
        e.tag = tag;
        q.push_back(e);
    endtask

    logic [3:0] hg[10];
    logic [1:0] hs[10];

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        In  = 4'b0000;
`ifdef MUX_ARB_HOLD_LIMIT_EN
        hg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
               4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
        hs = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1,
               2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
`else
        hg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
               4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        hs = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
               2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        // reset held two cycles with all requests high
        step(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, "reset1");
        step(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, "reset2");
        // round-robin with one-cycle drops, ptr wraps 3->0
        step(0, 4'b1110, 4'b0000, 4'b0001, 2'd0, 0, "rr0");
        step(0, 4'b1101, 4'b0000, 4'b0010, 2'd1, 0, "rr1");
        step(0, 4'b1011, 4'b0000, 4'b0100, 2'd2, 0, "rr2");
        step(0, 4'b0111, 4'b0000, 4'b1000, 2'd3, 0, "rr3");
        step(0, 4'b0000, 4'b0000, 4'b0001, 2'd0, 0, "rr0b");
        // data steering through Sel = 2
        step(0, 4'b0100, 4'b0100, 4'b0000, 2'd0, 0, "idle");
        step(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, "steer1");
        step(0, 4'b0000, 4'b1011, 4'b0100, 2'd2, 0, "steer0");
        // release to idle, then a 3-cycle req[1] pulse
        step(0, 4'b0010, 4'b1111, 4'b0000, 2'd2, 0, "rel_idle");
        step(0, 4'b0010, 4'b1111, 4'b0010, 2'd1, 1, "pulse1");
        step(0, 4'b0010, 4'b1111, 4'b0010, 2'd1, 1, "pulse2");
        step(0, 4'b0000, 4'b1111, 4'b0010, 2'd1, 1, "pulse3");
        step(0, 4'b0011, 4'b0000, 4'b0000, 2'd1, 0, "pulse_end");
        // two requesters held constantly
        for (int i = 0; i < 10; i++) begin
            step(0, (i == 9) ? 4'b0000 : 4'b0011, 4'b0000,
                 hg[i], hs[i], 0, "hold");
        end
        // mid-grant reset while requester 3 holds the mux
        step(0, 4'b1000, 4'b0000, 4'b0000, 2'd0, 0, "pre_g3");
        step(1, 4'b1001, 4'b0000, 4'b1000, 2'd3, 0, "g3");
        step(0, 4'b1001, 4'b0000, 4'b0000, 2'd0, 0, "mid_rst");
        step(0, 4'b0000, 4'b0000, 4'b0001, 2'd0, 0, "post_rst");
        step(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "final_idle");
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mux_4to1_rr_arbiter.md
# mux_4to1_rr_arbiter

Round-robin arbiter that shares a 4:1 one-bit mux between four requesters. It grants one requester at a time, drives the mux select `Sel[1:0]` from the registered grant, and presents the selected data bit on `out`. A grant is held while its request stays high. An optional hold limit forces rotation so no requester can starve the others. It sits in front of the 4:1 mux datapath, in place of a hard-wired `Sel`.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles a grant is held while other requests pend. Only used when `MUX_ARB_HOLD_LIMIT_EN` is defined. Legal range 2..255.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 4: per-requester request, level-sensitive; bit k belongs to requester k.
- `In` input 4: per-requester data bit; `In[k]` belongs to requester k.
- `Sel` output 2: registered mux select, the binary index of the current grantee.
- `gnt` output 4: registered one-hot grant; all zeros when idle.
- `busy` output 1: registered; 1 when any grant is active (`busy == |gnt`).
- `out` output 1: combinational `In[Sel] & busy`.

## Operation
- State machine: IDLE, GRANT. Internal registers:
  - `ptr[1:0]`, the round-robin start index.
  - `hold_cnt[7:0]`, present only when the hold limit is compiled in.
- Arbitration function `pick(ptr, mask)`: the first set bit of `mask`, searching `ptr, ptr+1, ptr+2, ptr+3` (mod 4).
- IDLE:
  - If `req != 0`: `k = pick(ptr, req)`, load `gnt = 1<<k`, `Sel = k`, `busy = 1`, `ptr = k+1` (mod 4), clear `hold_cnt`, go to GRANT.
  - Otherwise stay in IDLE with outputs 0.
- GRANT, current grantee `s = Sel`:
  - If `req[s] == 1` and no forced rotation: hold the grant and increment `hold_cnt`.
  - If `req[s] == 0` and `req & ~(1<<s) != 0`: zero-bubble handoff. `k = pick(ptr, req & ~(1<<s))`, load the new grant, `ptr = k+1`, clear `hold_cnt`.
  - If `req[s] == 0` and no other request: clear `gnt` and `busy`, go to IDLE. `Sel` keeps its last value.
- Forced rotation (limit enabled only):
  - Condition: `hold_cnt == HOLD_MAX-1` and other requests pend. Result: handoff as above, even though `req[s]` is still 1.
  - If no other request pends, the grant continues and `hold_cnt` clears to 0.
- Requests arriving while a grant holds are not queued; they are seen at the next handoff.
- `out` follows `In[Sel]` with no register, matching the dataflow mux. It is 0 whenever `busy == 0`.

## Timing
- Reset values: `gnt = 0`, `Sel = 0`, `busy = 0`, `out = 0`, `ptr = 0`, `hold_cnt = 0`, state IDLE.
- `rst` overrides all other inputs. Asserting it mid-grant clears everything at the next edge, and the first grant after reset restarts from `ptr = 0`.
- Request-to-grant latency: 1 cycle. `req` is sampled at edge N and `gnt`/`Sel` are valid after edge N.
- Release-to-next-grant: 0 idle cycles. The new grant is visible the cycle after the old grantee's `req` is seen low.
- Grant-release latency: `gnt` clears one cycle after the last `req` drops.
- Data path: `out` is valid in the same cycle as `In` changes, once `Sel`/`busy` are stable.
- Simultaneous requests resolve strictly by `ptr` order; there is no fixed priority.
- `ptr` wraps from 3 to 0.
- Invariants, every cycle:
  - `gnt` is one-hot or zero.
  - When `busy == 1`, `gnt == 1 << Sel`.

## Configuration
- `MUX_ARB_HOLD_LIMIT_EN` defined: `hold_cnt` and forced rotation after `HOLD_MAX` consecutive grant cycles are compiled in, whenever other requests pend.
- Undefined: `hold_cnt` and forced rotation are absent. A grantee holds the mux for as long as its `req` stays high, and `HOLD_MAX` is ignored.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `req = 4'b1111` -> `gnt = 0`, `Sel = 0`, `busy = 0`, `out = 0`. Deassert -> next cycle `gnt = 4'b0001`, `Sel = 0`.
- **Round-robin:** `req = 4'b1111`, and each grantee drops its req for 1 cycle after 1 cycle of grant -> grant order 0, 1, 2, 3, 0, with no idle cycle between grants.
- **Data steering:** `req = 4'b0100`, `In = 4'b0100` -> `Sel = 2`, `out = 1`. Change `In` to `4'b1011` -> `out = 0` in the same cycle.
- **Release to idle:** single `req[1]` pulse of 3 cycles -> `gnt = 4'b0010` for 3 cycles starting 1 cycle after assertion, then `gnt = 0`, `busy = 0`, `Sel` stays 1.
- **Hold limit (macro on, `HOLD_MAX = 4`):** `req = 4'b0011` held constantly -> `gnt` alternates `0001` and `0010` every 4 cycles. With the macro off -> `gnt` stays `0001` indefinitely.
- **Mid-grant reset:** grant to requester 3 with `ptr = 0`, then pulse `rst` for 1 cycle while `req = 4'b1001` -> outputs clear, and the next grant goes to requester 0.
